mem_bus: RTL and testbench
==========================

# mem_bus

Memory-access pipeline stage sitting between the ex_mem register and the mem_wb register. It executes loads and stores against a synchronous request/acknowledge data bus, generating byte-lane selects and big-endian sign/zero extension. It holds the pipeline via a stall request until the access completes, then presents the write-back triple that mem_wb captures. Non-memory instructions pass through combinationally with zero added latency.

## Interface
- No parameters. Opcode and state encodings come from `defines.v`.
- clk  in  1  Pipeline clock; all state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset (`RstEnable`).
- stall  in  6  Ctrl stall vector; bit 4 is `Stop` while mem_wb must not capture.
- mem_op  in  4  Memory opcode: NOP=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8.
- mem_addr  in  32  Effective byte address.
- mem_store_data  in  32  Store operand (rt).
- ex_reg_waddr  in  5  Destination register.
- ex_reg_we  in  1  Register write enable.
- ex_reg_wdata  in  32  ALU result for non-load instructions.
- dbus_ack  in  1  Access complete; rdata valid in the same cycle.
- dbus_rdata  in  32  Read word.
- dbus_req, dbus_we  out  1  Request and write strobe; registered.
- dbus_sel  out  4  Byte-lane enable; bit 3 selects bits 31:24. Registered.
- dbus_addr  out  32  Word-aligned address (bits 1:0 = 0); registered.
- dbus_wdata  out  32  Lane-replicated store data; registered.
- mem_reg_waddr, mem_reg_we, mem_reg_wdata  out  5/1/32  Write-back triple to mem_wb.
- stallreq_mem  out  1  Stall request to ctrl; combinational.
- excp_adel, excp_ades  out  1  Misaligned load/store flag; combinational.

## Operation
- Non-memory op (NOP): outputs follow the ex_* inputs; stallreq_mem=0.
- Alignment rules:
  - LH, LHU, SH require addr[0]=0.
  - LW, SW require addr[1:0]=0.
  - On violation: excp_adel (loads) or excp_ades (stores)=1, mem_reg_we=0, no bus access, stallreq_mem=0.
- FSM states: IDLE, REQ, DONE.
  - IDLE, aligned memory op: stallreq_mem=1. Next edge latches dbus_addr/sel/wdata/we, sets dbus_req=1, enters REQ.
  - REQ: stallreq_mem=1; dbus_req held high and bus outputs stable until dbus_ack. On ack: latch dbus_rdata, drop dbus_req, enter DONE.
  - DONE: stallreq_mem=0; write-back triple is driven.
    - Loads: mem_reg_wdata = extended latched data.
    - Stores: mem_reg_we = ex_reg_we.
    - Exits to IDLE on the first edge with stall[4]=`NoStop`; otherwise holds DONE.
- Lane map (big-endian):
  - Byte: offset 0→1000, 1→0100, 2→0010, 3→0001.
  - Half: offset 0→1100, 2→0011.
  - Word: 1111.
- Store data replication: SB {4{rt[7:0]}}, SH {2{rt[15:0]}}, SW rt.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend; LW uses the raw word.
- While stallreq_mem=1: mem_reg_we=0 (defensive; mem_wb inserts a bubble anyway).
- dbus_ack outside REQ is ignored.

## Timing
- Reset values:
  - state=IDLE; dbus_req=0, dbus_we=0, dbus_sel=0, dbus_addr=0, dbus_wdata=0; read latch=0.
  - Combinational outputs follow the inputs: stallreq_mem=0 when mem_op=NOP.
- Access with ack N≥1 cycles after dbus_req rises: 1 (IDLE) + N (REQ) + 1 (DONE) cycles. This gives N+1 stall cycles; mem_wb captures at the end of DONE.
- Ack in the first REQ cycle gives the minimum: 3 cycles, 2 stalls.
- Reset during REQ or DONE: IDLE and dbus_req=0 on the next edge. A late ack is ignored; the aborted access produces no write-back.
- Back-to-back memory ops: the next op's IDLE cycle directly follows DONE. There are no idle bus cycles beyond that.
- Combinational paths run from mem_op/mem_addr/state to stallreq_mem and excp_*. Ctrl must not feed stall back into mem_op.

## Structure
- `defines.v` holds:
  - `MEM_NOP`…`MEM_SW` opcodes.
  - State encodings `MEMS_IDLE/REQ/DONE`.
  - The existing `Stop/NoStop`, `RstEnable`, `RegWDisable`.
- Sub-module mem_align (combinational) computes:
  - Lane select and store replication from op/addr/rt.
  - Load extension from op/addr/rdata.
- mem_bus contains the FSM, bus registers and read latch.

## Test plan
- ALU op with ex_reg_waddr=5, ex_reg_wdata=0x1234 → same cycle mem_reg_*=(5,1,0x1234), stallreq_mem=0, dbus_req stays 0.
- LB at addr 0x103, ack 1 cycle after req, rdata=0x11223380:
  - dbus_addr=0x100, sel=0001.
  - stallreq high 2 cycles.
  - DONE wdata=0xFFFFFF80; LBU variant gives 0x00000080.
- SH at addr 0x202, rt=0xAAAABEEF, ack after 3 cycles: dbus_we=1, sel=0011, wdata=0xBEEFBEEF, stallreq high 4 cycles.
- LW at addr 0x6 → excp_adel=1, mem_reg_we=0, no dbus_req, stallreq_mem=0.
- Reset asserted in REQ, then ack arrives the next cycle → dbus_req=0 after the edge, state IDLE, no write-back issued.
- stall[4] held `Stop` by ctrl in DONE for 2 extra cycles → outputs stable and DONE held, then IDLE after the first `NoStop` edge.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared definitions for the memory-access stage.
//   - mem_op_e     : memory opcode encoding carried on mem_op.
//   - mem_state_e  : bus FSM state encoding.
//   - Stop/NoStop, reset-enable and write-disable levels.
//   - Opcode classification helpers used by mem_bus and mem_align.
package mem_bus_pkg;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LBU = 4'd2,
    MEM_LH  = 4'd3,
    MEM_LHU = 4'd4,
    MEM_LW  = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    MEMS_IDLE = 2'd0,
    MEMS_REQ  = 2'd1,
    MEMS_DONE = 2'd2
  } mem_state_e;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic STOP          = 1'b1;
  localparam logic NO_STOP       = 1'b0;
  localparam logic REG_W_DISABLE = 1'b0;
  // Bit of the ctrl stall vector that freezes the mem_wb register.
  localparam int   STALL_MEMWB_BIT = 4;

  function automatic logic op_is_load(input logic [3:0] op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  // Halfwords need an even address, words need a multiple of four.
  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
    return ((op inside {MEM_LH, MEM_LHU, MEM_SH}) && off[0]) ||
           ((op inside {MEM_LW, MEM_SW}) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_bus_align.sv
// mem_align: purely combinational big-endian lane logic.
//   i_op        : memory opcode
//   i_off       : byte offset within the word (addr[1:0])
//   i_rt        : store operand
//   i_rdata     : latched read word
//   o_sel       : byte-lane enables, bit 3 = bits 31:24
//   o_wdata     : store data replicated onto every candidate lane
//   o_load_data : selected and sign/zero-extended load result
module mem_align
  import mem_bus_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rt,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  // Byte at offset k lives in bits 31-8k..24-8k (big-endian).
  logic [7:0]  w_byte [4];
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_byte[gi] = i_rdata[31-8*gi -: 8];
    end
  endgenerate

  assign w_ld_byte = w_byte[i_off];
  assign w_ld_half = i_off[1] ? i_rdata[15:0] : i_rdata[31:16];

  always_comb begin
    o_sel   = 4'b0000;
    o_wdata = i_rt;
    case (i_op)
      MEM_LB, MEM_LBU, MEM_SB: begin
        o_sel   = 4'b1000 >> i_off;
        o_wdata = {4{i_rt[7:0]}};
      end
      MEM_LH, MEM_LHU, MEM_SH: begin
        o_sel   = i_off[1] ? 4'b0011 : 4'b1100;
        o_wdata = {2{i_rt[15:0]}};
      end
      MEM_LW, MEM_SW: o_sel = 4'b1111;
      default: ;
    endcase
  end

  always_comb begin
    o_load_data = i_rdata;
    case (i_op)
      MEM_LB:  o_load_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      MEM_LBU: o_load_data = {24'd0, w_ld_byte};
      MEM_LH:  o_load_data = {{16{w_ld_half[15]}}, w_ld_half};
      MEM_LHU: o_load_data = {16'd0, w_ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus.sv
// mem_bus: memory-access pipeline stage between ex_mem and mem_wb.
//   clk, rst        : clock, synchronous active-high reset
//   stall[5:0]      : ctrl stall vector, bit 4 freezes mem_wb
//   mem_op/addr/store_data, ex_reg_* : instruction from ex_mem
//   dbus_ack/rdata  : bus completion and read word
//   dbus_req/we/sel/addr/wdata : registered bus request
//   mem_reg_*       : write-back triple to mem_wb
//   stallreq_mem    : combinational stall request to ctrl
//   excp_adel/ades  : combinational misaligned load/store flags
module mem_bus
  import mem_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_store_data,
  input  logic [4:0]  ex_reg_waddr,
  input  logic        ex_reg_we,
  input  logic [31:0] ex_reg_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [4:0]  mem_reg_waddr,
  output logic        mem_reg_we,
  output logic [31:0] mem_reg_wdata,
  output logic        stallreq_mem,
  output logic        excp_adel,
  output logic        excp_ades
);

  mem_state_e  r_state;
  mem_state_e  w_state_next;
  logic        r_dbus_req;
  logic        r_dbus_we;
  logic [3:0]  r_dbus_sel;
  logic [31:0] r_dbus_addr;
  logic [31:0] r_dbus_wdata;
  logic [31:0] r_rdata;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_misalign;
  logic        w_access;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;
  logic        w_unused;

  assign w_unused = ^{stall[5], stall[3:0]};

  mem_align u_align (
    .i_op        (mem_op),
    .i_off       (mem_addr[1:0]),
    .i_rt        (mem_store_data),
    .i_rdata     (r_rdata),
    .o_sel       (w_sel),
    .o_wdata     (w_wdata),
    .o_load_data (w_load_data)
  );

  assign w_is_load  = op_is_load(mem_op);
  assign w_is_store = op_is_store(mem_op);
  assign w_misalign = op_misaligned(mem_op, mem_addr[1:0]);
  // A misaligned op never touches the bus and never stalls.
  assign w_access   = (w_is_load || w_is_store) && !w_misalign;

  assign excp_adel = w_is_load && w_misalign;
  assign excp_ades = w_is_store && w_misalign;

  // State register plus bus/read-latch registers.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state      <= MEMS_IDLE;
      r_dbus_req   <= 1'b0;
      r_dbus_we    <= 1'b0;
      r_dbus_sel   <= 4'b0000;
      r_dbus_addr  <= 32'd0;
      r_dbus_wdata <= 32'd0;
      r_rdata      <= 32'd0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        MEMS_IDLE: begin
          if (w_access) begin
            r_dbus_req   <= 1'b1;
            r_dbus_we    <= w_is_store;
            r_dbus_sel   <= w_sel;
            r_dbus_addr  <= {mem_addr[31:2], 2'b00};
            r_dbus_wdata <= w_wdata;
          end
        end
        MEMS_REQ: begin
          if (dbus_ack) begin
            r_rdata    <= dbus_rdata;
            r_dbus_req <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MEMS_IDLE: if (w_access) w_state_next = MEMS_REQ;
      MEMS_REQ:  if (dbus_ack) w_state_next = MEMS_DONE;
      MEMS_DONE: if (stall[STALL_MEMWB_BIT] == NO_STOP) w_state_next = MEMS_IDLE;
      default:   w_state_next = MEMS_IDLE;
    endcase
  end

  // Output logic: non-memory ops pass straight through; loads swap in the
  // extended read data only once the access has completed.
  always_comb begin
    stallreq_mem  = w_access && (r_state != MEMS_DONE);
    mem_reg_waddr = ex_reg_waddr;
    mem_reg_we    = ex_reg_we;
    mem_reg_wdata = ex_reg_wdata;
    if (w_misalign || stallreq_mem) begin
      mem_reg_we = REG_W_DISABLE;
    end
    if ((r_state == MEMS_DONE) && w_access && w_is_load) begin
      mem_reg_wdata = w_load_data;
    end
  end

  assign dbus_req   = r_dbus_req;
  assign dbus_we    = r_dbus_we;
  assign dbus_sel   = r_dbus_sel;
  assign dbus_addr  = r_dbus_addr;
  assign dbus_wdata = r_dbus_wdata;

endmodule

// File: tb/tb_mem_bus.sv
// tb_mem_bus: table-driven self-checking bench for mem_bus with a
// write-back scoreboard, plus hand sequences for reset-in-REQ and
// DONE hold under stall.
module tb_mem_bus;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_store_data;
  logic [4:0]  ex_reg_waddr;
  logic        ex_reg_we;
  logic [31:0] ex_reg_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        dbus_req;
  logic        dbus_we;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [4:0]  mem_reg_waddr;
  logic        mem_reg_we;
  logic [31:0] mem_reg_wdata;
  logic        stallreq_mem;
  logic        excp_adel;
  logic        excp_ades;

  always #5 clk = ~clk;

  mem_bus dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .mem_op         (mem_op),
    .mem_addr       (mem_addr),
    .mem_store_data (mem_store_data),
    .ex_reg_waddr   (ex_reg_waddr),
    .ex_reg_we      (ex_reg_we),
    .ex_reg_wdata   (ex_reg_wdata),
    .dbus_ack       (dbus_ack),
    .dbus_rdata     (dbus_rdata),
    .dbus_req       (dbus_req),
    .dbus_we        (dbus_we),
    .dbus_sel       (dbus_sel),
    .dbus_addr      (dbus_addr),
    .dbus_wdata     (dbus_wdata),
    .mem_reg_waddr  (mem_reg_waddr),
    .mem_reg_we     (mem_reg_we),
    .mem_reg_wdata  (mem_reg_wdata),
    .stallreq_mem   (stallreq_mem),
    .excp_adel      (excp_adel),
    .excp_ades      (excp_ades)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] rdata;
    int          ack_n;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] alu;
    logic [31:0] exp_wdata;
    logic        exp_we;
    int          exp_stall;
    logic        exp_adel;
    logic        exp_ades;
    logic        exp_bwe;
    logic [3:0]  exp_sel;
    logic [31:0] exp_baddr;
    logic [31:0] exp_bwdata;
  } vec_t;

  typedef struct {
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    logic        chk_wdata;
  } wb_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];
  wb_t  sb_q [$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
  endtask

  task automatic set_vec(input int i, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] rt, input logic [31:0] rdata, input int ack_n,
                         input logic [4:0] waddr, input logic we, input logic [31:0] alu,
                         input logic [31:0] exp_wdata, input logic exp_we, input int exp_stall,
                         input logic exp_adel, input logic exp_ades, input logic exp_bwe,
                         input logic [3:0] exp_sel, input logic [31:0] exp_baddr,
                         input logic [31:0] exp_bwdata);
    vecs[i].op = op;           vecs[i].addr = addr;         vecs[i].rt = rt;
    vecs[i].rdata = rdata;     vecs[i].ack_n = ack_n;       vecs[i].waddr = waddr;
    vecs[i].we = we;           vecs[i].alu = alu;           vecs[i].exp_wdata = exp_wdata;
    vecs[i].exp_we = exp_we;   vecs[i].exp_stall = exp_stall;
    vecs[i].exp_adel = exp_adel; vecs[i].exp_ades = exp_ades;
    vecs[i].exp_bwe = exp_bwe; vecs[i].exp_sel = exp_sel;   vecs[i].exp_baddr = exp_baddr;
    vecs[i].exp_bwdata = exp_bwdata;
  endtask

  // Applies one instruction (called #1 after a rising edge), plays the bus
  // slave, and checks the write-back when the stage stops stalling.
  task automatic run_vec(input int idx);
    vec_t v;
    wb_t  e;
    wb_t  exp_wb;
    int   stalls = 0;
    int   reqc = 0;
    int   cyc = 0;
    logic done = 1'b0;
    logic saw_req = 1'b0;
    v = vecs[idx];
    mem_op = v.op;  mem_addr = v.addr;  mem_store_data = v.rt;
    ex_reg_waddr = v.waddr;  ex_reg_we = v.we;  ex_reg_wdata = v.alu;
    dbus_rdata = v.rdata;  dbus_ack = 1'b0;
    e.waddr = v.waddr;  e.we = v.exp_we;  e.wdata = v.exp_wdata;
    e.chk_wdata = !(v.exp_adel || v.exp_ades);
    sb_q.push_back(e);
    while (!done && cyc < 40) begin
      if (dbus_req) begin
        reqc++;
        dbus_ack = (reqc == v.ack_n);
      end else begin
        dbus_ack = 1'b0;
      end
      @(negedge clk);
      if (dbus_req) begin
        saw_req = 1'b1;
        chk($sformatf("v%0d_bus_addr", idx), dbus_addr, v.exp_baddr);
        chk($sformatf("v%0d_bus_sel", idx), {28'd0, dbus_sel}, {28'd0, v.exp_sel});
        chk($sformatf("v%0d_bus_we", idx), {31'd0, dbus_we}, {31'd0, v.exp_bwe});
        if (v.exp_bwe) chk($sformatf("v%0d_bus_wdata", idx), dbus_wdata, v.exp_bwdata);
      end
      if (stallreq_mem) begin
        stalls++;
        chk($sformatf("v%0d_we_in_stall", idx), {31'd0, mem_reg_we}, 32'd0);
      end else begin
        done = 1'b1;
        exp_wb = sb_q.pop_front();
        chk($sformatf("v%0d_wb_waddr", idx), {27'd0, mem_reg_waddr}, {27'd0, exp_wb.waddr});
        chk($sformatf("v%0d_wb_we", idx), {31'd0, mem_reg_we}, {31'd0, exp_wb.we});
        if (exp_wb.chk_wdata) chk($sformatf("v%0d_wb_wdata", idx), mem_reg_wdata, exp_wb.wdata);
        chk($sformatf("v%0d_adel", idx), {31'd0, excp_adel}, {31'd0, v.exp_adel});
        chk($sformatf("v%0d_ades", idx), {31'd0, excp_ades}, {31'd0, v.exp_ades});
        chk($sformatf("v%0d_stalls", idx), stalls, v.exp_stall);
        chk($sformatf("v%0d_saw_req", idx), {31'd0, saw_req}, {31'd0, (v.exp_stall > 0)});
        $display("txn %0d op=%0d addr=0x%08h wb=(%0d,%0d,0x%08h) stalls=%0d",
                 idx, v.op, v.addr, mem_reg_waddr, mem_reg_we, mem_reg_wdata, stalls);
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) chk($sformatf("v%0d_timeout", idx), {31'd0, done}, 32'd1);
    mem_op = MEM_NOP;  ex_reg_we = 1'b0;  dbus_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;  stall = 6'd0;  mem_op = MEM_NOP;  mem_addr = 32'd0;
    mem_store_data = 32'd0;  ex_reg_waddr = 5'd0;  ex_reg_we = 1'b0;
    ex_reg_wdata = 32'd0;  dbus_ack = 1'b0;  dbus_rdata = 32'd0;

    //        idx op       addr   rt          rdata        ack wa  we alu     exp_wdata    ewe st adel ades bwe sel      baddr   bwdata
    set_vec(0,  MEM_NOP, 32'h0,   32'h0,        32'h0,        0, 5,  1, 32'h1234, 32'h1234,     1, 0, 0, 0, 0, 4'b0000, 32'h0,   32'h0);
    set_vec(1,  MEM_LB,  32'h103, 32'h0,        32'h11223380, 1, 3,  1, 32'h103,  32'hFFFFFF80, 1, 2, 0, 0, 0, 4'b0001, 32'h100, 32'h0);
    set_vec(2,  MEM_LBU, 32'h103, 32'h0,        32'h11223380, 1, 4,  1, 32'h103,  32'h00000080, 1, 2, 0, 0, 0, 4'b0001, 32'h100, 32'h0);
    set_vec(3,  MEM_SH,  32'h202, 32'hAAAABEEF, 32'h0,        3, 0,  0, 32'h202,  32'h202,      0, 4, 0, 0, 1, 4'b0011, 32'h200, 32'hBEEFBEEF);
    set_vec(4,  MEM_LW,  32'h6,   32'h0,        32'h0,        0, 8,  1, 32'h6,    32'h6,        0, 0, 1, 0, 0, 4'b0000, 32'h0,   32'h0);
    set_vec(5,  MEM_LH,  32'h102, 32'h0,        32'h11228001, 2, 10, 1, 32'h102,  32'hFFFF8001, 1, 3, 0, 0, 0, 4'b0011, 32'h100, 32'h0);
    set_vec(6,  MEM_LHU, 32'h100, 32'h0,        32'h80011122, 1, 11, 1, 32'h100,  32'h00008001, 1, 2, 0, 0, 0, 4'b1100, 32'h100, 32'h0);
    set_vec(7,  MEM_LW,  32'h10,  32'h0,        32'hDEADBEEF, 2, 12, 1, 32'h10,   32'hDEADBEEF, 1, 3, 0, 0, 0, 4'b1111, 32'h10,  32'h0);
    set_vec(8,  MEM_SB,  32'h301, 32'h123456A5, 32'h0,        1, 0,  0, 32'h301,  32'h301,      0, 2, 0, 0, 1, 4'b0100, 32'h300, 32'hA5A5A5A5);
    set_vec(9,  MEM_SW,  32'h404, 32'hCAFEF00D, 32'h0,        1, 14, 1, 32'h404,  32'h404,      1, 2, 0, 0, 1, 4'b1111, 32'h404, 32'hCAFEF00D);
    set_vec(10, MEM_SW,  32'h405, 32'h1,        32'h0,        0, 15, 1, 32'h405,  32'h405,      0, 0, 0, 1, 0, 4'b0000, 32'h0,   32'h0);
    set_vec(11, MEM_LB,  32'h0,   32'h0,        32'h7F000000, 1, 13, 1, 32'h0,    32'h0000007F, 1, 2, 0, 0, 0, 4'b1000, 32'h0,   32'h0);
    set_vec(12, MEM_SH,  32'h203, 32'h1,        32'h0,        0, 16, 1, 32'h203,  32'h203,      0, 0, 0, 1, 0, 4'b0000, 32'h0,   32'h0);
    set_vec(13, MEM_LH,  32'h101, 32'h0,        32'h0,        0, 17, 1, 32'h101,  32'h101,      0, 0, 1, 0, 0, 4'b0000, 32'h0,   32'h0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req",     {31'd0, dbus_req}, 32'd0);
    chk("rst_we",      {31'd0, dbus_we}, 32'd0);
    chk("rst_sel",     {28'd0, dbus_sel}, 32'd0);
    chk("rst_addr",    dbus_addr, 32'd0);
    chk("rst_wdata",   dbus_wdata, 32'd0);
    chk("rst_stallrq", {31'd0, stallreq_mem}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Reset while in REQ: access is abandoned, late ack ignored.
    mem_op = MEM_LW;  mem_addr = 32'h20;  ex_reg_waddr = 5'd9;  ex_reg_we = 1'b1;
    ex_reg_wdata = 32'h0;  dbus_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rq_req_before_rst", {31'd0, dbus_req}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;  mem_op = MEM_NOP;  ex_reg_we = 1'b0;  dbus_ack = 1'b1;
    @(negedge clk);
    chk("rq_req_after_rst",  {31'd0, dbus_req}, 32'd0);
    chk("rq_sel_after_rst",  {28'd0, dbus_sel}, 32'd0);
    chk("rq_addr_after_rst", dbus_addr, 32'd0);
    @(posedge clk); #1;
    dbus_ack = 1'b0;  mem_op = MEM_LW;  mem_addr = 32'h24;  ex_reg_we = 1'b1;
    dbus_rdata = 32'h55667788;
    @(negedge clk);
    chk("rq_new_op_stalls",  {31'd0, stallreq_mem}, 32'd1);
    chk("rq_new_op_no_wb",   {31'd0, mem_reg_we}, 32'd0);
    @(posedge clk); #1;
    dbus_ack = 1'b1;
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    @(negedge clk);
    chk("rq_done_stall", {31'd0, stallreq_mem}, 32'd0);
    chk("rq_done_wdata", mem_reg_wdata, 32'h55667788);
    chk("rq_done_we",    {31'd0, mem_reg_we}, 32'd1);
    $display("txn rst_in_req wb=(%0d,%0d,0x%08h)", mem_reg_waddr, mem_reg_we, mem_reg_wdata);
    @(posedge clk); #1;
    mem_op = MEM_NOP;  ex_reg_we = 1'b0;

    // DONE held for two cycles by Stop, released by NoStop.
    mem_op = MEM_LW;  mem_addr = 32'h30;  ex_reg_waddr = 5'd7;  ex_reg_we = 1'b1;
    dbus_rdata = 32'h01020304;
    @(posedge clk); #1;
    dbus_ack = 1'b1;
    @(posedge clk); #1;
    dbus_ack = 1'b0;  dbus_rdata = 32'hFFFFFFFF;
    stall[STALL_MEMWB_BIT] = STOP;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_stall", k), {31'd0, stallreq_mem}, 32'd0);
      chk($sformatf("hold%0d_wdata", k), mem_reg_wdata, 32'h01020304);
      chk($sformatf("hold%0d_we", k),    {31'd0, mem_reg_we}, 32'd1);
      if (k == 2) stall[STALL_MEMWB_BIT] = NO_STOP;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("hold_exit_idle", {31'd0, stallreq_mem}, 32'd1);
    chk("hold_exit_req",  {31'd0, dbus_req}, 32'd0);
    $display("txn stall_hold wb=(%0d,%0d,0x%08h)", mem_reg_waddr, mem_reg_we, mem_reg_wdata);
    mem_op = MEM_NOP;  ex_reg_we = 1'b0;
    @(posedge clk); #1;

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
